dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: latches one LSU request, runs it on a
// request/grant/response bus and returns read data or an error with a one-cycle ready.
module dmem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,   // RISCV_ADDR_WIDTH
    parameter int DATA_W  = 32    // RISCV_WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_valid_i,
    output logic              dmem_ready_o,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic [3:0]        dmem_we_i,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              dmem_err_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        we_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic launch;
    logic in_flight;
    logic resp_accept;
    logic timeout_hit;

    always_comb begin
        launch      = (state_reg == IDLE) && dmem_valid_i;
        in_flight   = (state_reg == REQ) || (state_reg == RESP);
        // A response only counts once the bus has granted the request.
        resp_accept = ((state_reg == REQ) && bus_gnt_i && bus_rvalid_i) ||
                      ((state_reg == RESP) && bus_rvalid_i);
        timeout_hit = (TIMEOUT != 0) && in_flight && !resp_accept && (cnt_reg == CNT_LAST);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (dmem_valid_i) state_next = REQ;
            REQ: begin
                if (resp_accept || timeout_hit) state_next = DONE;
                else if (bus_gnt_i)             state_next = RESP;
            end
            RESP: if (resp_accept || timeout_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                addr_reg  <= dmem_addr_i;
                wdata_reg <= dmem_wdata_i;
                we_reg    <= dmem_we_i;
                cnt_reg   <= '0;
            end else if (in_flight) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (resp_accept) begin
                err_reg <= bus_err_i;
                // Writes keep the last read value visible to the LSU.
                if (we_reg == 4'b0000)
                    rdata_reg <= bus_err_i ? '0 : bus_rdata_i;
            end else if (timeout_hit) begin
                err_reg   <= 1'b1;
                rdata_reg <= '0;
            end
        end
    end

    assign dmem_ready_o = (state_reg == DONE);
    assign dmem_rdata_o = rdata_reg;
    assign dmem_err_o   = err_reg;
    assign bus_req_o    = (state_reg == REQ);
    assign bus_addr_o   = addr_reg & ~(ADDR_W'(3));
    assign bus_we_o     = |we_reg;
    assign bus_wdata_o  = wdata_reg;

    // Reads enable every lane; writes pass the strobes through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign bus_be_o[gi] = we_reg[gi] | ~bus_we_o;
        end
    endgenerate

endmodule
